// File: rtl/model_lstm_buffer_pkg.sv
// Shared types and defaults for the LSTM hidden-state capture/replay buffer.
// Holds the FSM state encoding and the vector-length validity rule.
package model_lstm_buffer_pkg;

    localparam int L_MAX_DEF     = 64;
    localparam int ADDR_SIZE_DEF = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STORED  = 2'd2,
        REPLAY  = 2'd3
    } state_t;

    // A vector length is usable when it is non-zero and fits the store; any
    // stray upper bit makes the value exceed l_max and so fails too.
    function automatic logic size_valid(input logic [63:0] size, input int unsigned l_max);
        return (size != 64'd0) && (size <= 64'(l_max));
    endfunction

endpackage

// File: rtl/model_lstm_buffer_ram.sv
// Vector store: one write port, one read port, read data registered (1 cycle).
// No backpressure; rd_dat holds its value between reads and clears on reset.
module model_lstm_buffer_ram #(
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 64,
    parameter int ADDR_SIZE = 6
) (
    input  logic                 core_clk,
    input  logic                 rst_n,
    input  logic                 wr_vld,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_dat,
    input  logic                 rd_vld,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_dat
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_vld) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/model_convolutional_lstm_hidden_buffer.sv
// Captures the serial H_OUT stream into a vector store and replays it as H_IN.
// Replay latency 1 cycle, 1 element/cycle; no backpressure, misuse raises sticky flags.
module model_convolutional_lstm_hidden_buffer
    import model_lstm_buffer_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int L_MAX        = L_MAX_DEF,
    parameter int ADDR_SIZE    = ADDR_SIZE_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_SIZE-1:0] SIZE_L_IN,
    input  logic                 CAPTURE_START,
    input  logic [DATA_SIZE-1:0] H_OUT,
    input  logic                 H_OUT_ENABLE,
    input  logic                 REPLAY_START,
    input  logic                 H_IN_REQUEST,
    output logic [DATA_SIZE-1:0] H_IN,
    output logic                 H_IN_ENABLE,
    output logic                 CAPTURED,
    output logic                 BUSY,
    output logic [ADDR_SIZE:0]   COUNT,
    output logic                 SIZE_ERROR,
    output logic                 OVERFLOW,
    output logic                 UNDERRUN
);

    localparam logic [ADDR_SIZE:0] CNT_ONE = (ADDR_SIZE + 1)'(1);

    state_t               state;
    logic [ADDR_SIZE:0]   vec_len;
    logic                 size_ok;
    logic                 start_ok;
    logic                 start_bad;
    logic                 last_elem;
    logic                 wr_vld;
    logic                 rd_vld;
    logic [ADDR_SIZE-1:0] elem_addr;

    // COUNT doubles as the element index: both clear and advance together.
    always_comb begin
        size_ok   = size_valid(64'(SIZE_L_IN), L_MAX);
        start_ok  = CAPTURE_START && size_ok;
        start_bad = CAPTURE_START && !size_ok;
        elem_addr = COUNT[ADDR_SIZE-1:0];
        last_elem = (COUNT + CNT_ONE) == vec_len;
        wr_vld    = (state == CAPTURE) && H_OUT_ENABLE && !start_ok;
        rd_vld    = (state == REPLAY) && H_IN_REQUEST && !start_ok;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            vec_len     <= '0;
            COUNT       <= '0;
            CAPTURED    <= 1'b0;
            BUSY        <= 1'b0;
            H_IN_ENABLE <= 1'b0;
            SIZE_ERROR  <= 1'b0;
            OVERFLOW    <= 1'b0;
            UNDERRUN    <= 1'b0;
        end else begin
            H_IN_ENABLE <= rd_vld;
            if (start_ok) begin
                // An accepted start wins over everything else this cycle.
                state      <= CAPTURE;
                vec_len    <= SIZE_L_IN[ADDR_SIZE:0];
                COUNT      <= '0;
                CAPTURED   <= 1'b0;
                BUSY       <= 1'b1;
                SIZE_ERROR <= 1'b0;
                OVERFLOW   <= 1'b0;
                UNDERRUN   <= 1'b0;
            end else begin
                if (start_bad) begin
                    SIZE_ERROR <= 1'b1;
                end
                if (H_OUT_ENABLE && state != CAPTURE) begin
                    OVERFLOW <= 1'b1;
                end
                if (H_IN_REQUEST && state != REPLAY) begin
                    UNDERRUN <= 1'b1;
                end
                case (state)
                    CAPTURE: begin
                        if (wr_vld) begin
                            COUNT <= COUNT + CNT_ONE;
                            if (last_elem) begin
                                state    <= STORED;
                                CAPTURED <= 1'b1;
                                BUSY     <= 1'b0;
                            end
                        end
                    end
                    STORED: begin
                        if (REPLAY_START) begin
                            state <= REPLAY;
                            COUNT <= '0;
                            BUSY  <= 1'b1;
                        end
                    end
                    REPLAY: begin
                        if (rd_vld) begin
                            COUNT <= COUNT + CNT_ONE;
                            if (last_elem) begin
                                state <= STORED;
                                BUSY  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    model_lstm_buffer_ram #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (L_MAX),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .core_clk (CLK),
        .rst_n    (RST),
        .wr_vld   (wr_vld),
        .wr_addr  (elem_addr),
        .wr_dat   (H_OUT),
        .rd_vld   (rd_vld),
        .rd_addr  (elem_addr),
        .rd_dat   (H_IN)
    );

endmodule

// File: tb/tb_model_convolutional_lstm_hidden_buffer.sv
// Bench for the hidden-state buffer: directed scenarios then random traffic,
// every cycle compared against a vector/position reference model.
module tb_model_convolutional_lstm_hidden_buffer;

    localparam int DW = 64;
    localparam int AW = 6;
    localparam int LM = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] SIZE_L_IN;
    logic          CAPTURE_START;
    logic [DW-1:0] H_OUT;
    logic          H_OUT_ENABLE;
    logic          REPLAY_START;
    logic          H_IN_REQUEST;
    logic [DW-1:0] H_IN;
    logic          H_IN_ENABLE;
    logic          CAPTURED;
    logic          BUSY;
    logic [AW:0]   COUNT;
    logic          SIZE_ERROR;
    logic          OVERFLOW;
    logic          UNDERRUN;

    always #5 CLK = ~CLK;

    model_convolutional_lstm_hidden_buffer #(
        .DATA_SIZE (DW), .CONTROL_SIZE (4), .L_MAX (LM), .ADDR_SIZE (AW)
    ) dut (
        .CLK (CLK), .RST (RST), .SIZE_L_IN (SIZE_L_IN), .CAPTURE_START (CAPTURE_START),
        .H_OUT (H_OUT), .H_OUT_ENABLE (H_OUT_ENABLE), .REPLAY_START (REPLAY_START),
        .H_IN_REQUEST (H_IN_REQUEST), .H_IN (H_IN), .H_IN_ENABLE (H_IN_ENABLE),
        .CAPTURED (CAPTURED), .BUSY (BUSY), .COUNT (COUNT), .SIZE_ERROR (SIZE_ERROR),
        .OVERFLOW (OVERFLOW), .UNDERRUN (UNDERRUN)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    // Reference model: the stored vector, its length, and how far into it we are.
    typedef enum {M_IDLE, M_CAP, M_STO, M_REP} mode_e;
    mode_e         mode;
    logic [DW-1:0] vec [LM];
    int            len;
    int            pos;
    bit            m_cap, m_serr, m_ovf, m_unr, m_hen, m_hin_chk;
    logic [DW-1:0] m_hin;
    logic [DW-1:0] seen [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_update();
        m_hen     = 1'b0;
        m_hin_chk = 1'b0;
        if (!RST) begin
            mode = M_IDLE; len = 0; pos = 0;
            m_cap = 0; m_serr = 0; m_ovf = 0; m_unr = 0;
            m_hin = '0; m_hin_chk = 1'b1;
        end else if (CAPTURE_START && SIZE_L_IN >= 1 && SIZE_L_IN <= LM) begin
            mode = M_CAP; len = int'(SIZE_L_IN); pos = 0;
            m_cap = 0; m_serr = 0; m_ovf = 0; m_unr = 0;
        end else begin
            if (CAPTURE_START) m_serr = 1;
            if (H_OUT_ENABLE && mode != M_CAP) m_ovf = 1;
            if (H_IN_REQUEST && mode != M_REP) m_unr = 1;
            if (mode == M_CAP && H_OUT_ENABLE) begin
                vec[pos] = H_OUT;
                pos++;
                if (pos == len) begin
                    mode  = M_STO;
                    m_cap = 1;
                end
            end else if (mode == M_STO && REPLAY_START) begin
                mode = M_REP;
                pos  = 0;
            end else if (mode == M_REP && H_IN_REQUEST) begin
                m_hin = vec[pos]; m_hen = 1; m_hin_chk = 1;
                pos++;
                if (pos == len) mode = M_STO;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
        cyc_n++;
        chk("h_in_enable", H_IN_ENABLE, m_hen);
        if (m_hin_chk) chk("h_in", H_IN, m_hin);
        chk("captured", CAPTURED, m_cap);
        chk("busy", BUSY, (mode == M_CAP || mode == M_REP));
        chk("count", COUNT, 64'(pos));
        chk("size_error", SIZE_ERROR, m_serr);
        chk("overflow", OVERFLOW, m_ovf);
        chk("underrun", UNDERRUN, m_unr);
        if (H_IN_ENABLE) seen.push_back(H_IN);
    endtask

    task automatic drive(input bit r, input bit cs, input logic [DW-1:0] sz, input bit oe,
                         input logic [DW-1:0] ho, input bit rs, input bit rq);
        RST = r; CAPTURE_START = cs; SIZE_L_IN = sz; H_OUT_ENABLE = oe;
        H_OUT = ho; REPLAY_START = rs; H_IN_REQUEST = rq;
        tick();
    endtask

    task automatic idle_cyc();
        drive(1, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic reset_cyc();
        drive(0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic capture(input int n, input logic [DW-1:0] base);
        drive(1, 1, DW'(n), 0, '0, 0, 0);
        for (int i = 0; i < n; i++) drive(1, 0, '0, 1, base + DW'(i), 0, 0);
    endtask

    logic [DW-1:0] ref4 [4];

    initial begin
        ref4[0] = 64'h11; ref4[1] = 64'h22; ref4[2] = 64'h33; ref4[3] = 64'h44;
        reset_cyc();
        reset_cyc();

        // Basic capture then back-to-back replay.
        drive(1, 1, 64'd4, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, '0, 1, ref4[i], 0, 0);
        chk("t1_captured", CAPTURED, 1);
        chk("t1_count", COUNT, 4);
        seen.delete();
        drive(1, 0, '0, 0, '0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, '0, 0, '0, 0, 1);
        idle_cyc();
        chk("t1_len", 64'(seen.size()), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("t1_hin", seen[i], ref4[i]);
        chk("t1_busy", BUSY, 0);

        // Two gapped replays must give the same sequence.
        seen.delete();
        for (int rep = 0; rep < 2; rep++) begin
            drive(1, 0, '0, 0, '0, 1, 0);
            for (int i = 0; i < 4; i++) begin
                drive(1, 0, '0, 0, '0, 0, 1);
                idle_cyc();
                idle_cyc();
            end
        end
        chk("t2_len", 64'(seen.size()), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("t2_hin", seen[i], ref4[i % 4]);

        // Illegal sizes from IDLE, then a legal start clears the flag.
        reset_cyc();
        drive(1, 1, 64'd0, 0, '0, 0, 0);
        chk("t3_serr0", SIZE_ERROR, 1);
        chk("t3_cap0", CAPTURED, 0);
        reset_cyc();
        drive(1, 1, 64'd65, 0, '0, 0, 0);
        chk("t3_serr65", SIZE_ERROR, 1);
        chk("t3_busy65", BUSY, 0);
        drive(1, 1, 64'd2, 0, '0, 0, 0);
        chk("t3_serr_clr", SIZE_ERROR, 0);
        drive(1, 0, '0, 1, 64'hA0, 0, 0);
        drive(1, 0, '0, 1, 64'hA1, 0, 0);

        // Strobe in STORED flags OVERFLOW and leaves data alone.
        drive(1, 0, '0, 1, 64'hDEAD, 0, 0);
        chk("t4_ovf", OVERFLOW, 1);
        seen.delete();
        drive(1, 0, '0, 0, '0, 1, 0);
        drive(1, 0, '0, 0, '0, 0, 1);
        drive(1, 0, '0, 0, '0, 0, 1);
        idle_cyc();
        chk("t4_len", 64'(seen.size()), 2);
        if (seen.size() == 2) begin
            chk("t4_d0", seen[0], 64'hA0);
            chk("t4_d1", seen[1], 64'hA1);
        end
        reset_cyc();
        drive(1, 0, '0, 0, '0, 0, 1);
        chk("t4_unr", UNDERRUN, 1);
        idle_cyc();
        chk("t4_no_hen", H_IN_ENABLE, 0);

        // Capture and replay start together in STORED.
        capture(2, 64'h100);
        drive(1, 1, 64'd3, 0, '0, 1, 0);
        chk("t5_cap", CAPTURED, 0);
        chk("t5_count", COUNT, 0);
        chk("t5_busy", BUSY, 1);

        // Reset mid-capture.
        drive(1, 1, 64'd4, 0, '0, 0, 0);
        drive(1, 0, '0, 1, 64'h1, 0, 0);
        drive(1, 0, '0, 1, 64'h2, 0, 0);
        reset_cyc();
        chk("t6_count", COUNT, 0);
        chk("t6_busy", BUSY, 0);
        chk("t6_hin", H_IN, 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            bit            r, cs, oe, rs, rq;
            logic [DW-1:0] sz;
            int            k;
            r  = ($urandom_range(0, 299) != 0);
            cs = ($urandom_range(0, 29) == 0);
            k  = $urandom_range(0, 9);
            case (k)
                0:       sz = '0;
                1:       sz = 64'd65;
                2:       sz = {$urandom, $urandom};
                3:       sz = 64'd64;
                default: sz = DW'($urandom_range(1, 6));
            endcase
            oe = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 5) == 0);
            rq = ($urandom_range(0, 2) != 0);
            drive(r, cs, sz, oe, {$urandom, $urandom}, rs, rq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
